// File: rtl/spi_master_shifter.sv
// SPI mode-0 master shift engine. Detects edges of the divider's spi_clk by
// sampling it on m_clk, shifts tx words out on mosi and assembles miso into rx_data.
module spi_master_shifter #(
    parameter int DATA_W    = 8,
    parameter int LSB_FIRST = 0,
    parameter int CS_GAP    = 4
) (
    input  logic              m_clk,
    input  logic              nrst,
    input  logic              spi_clk,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              spi_cs,
    output logic              mosi,
    input  logic              miso
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int GAP_W = $clog2(CS_GAP + 1);
    localparam bit LSB   = (LSB_FIRST != 0);

    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

    state_t             state_reg, state_next;
    logic               spi_clk_q;
    logic [DATA_W-1:0]  tx_shift_reg, tx_shift_next;
    logic [DATA_W-1:0]  rx_shift_reg, rx_shift_next;
    logic [DATA_W-1:0]  rx_data_reg, rx_data_next;
    logic [CNT_W-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
    logic               spi_cs_reg, spi_cs_next;
    logic               mosi_reg, mosi_next;
    logic               tx_ready_reg, tx_ready_next;
    logic               rx_valid_reg, rx_valid_next;
    logic               busy_reg, busy_next;
    logic               rise, fall;

    assign rise = spi_clk & ~spi_clk_q;
    assign fall = ~spi_clk & spi_clk_q;

    always_ff @(posedge m_clk or negedge nrst) begin
        if (!nrst) begin
            state_reg    <= IDLE;
            spi_clk_q    <= 1'b0;
            tx_shift_reg <= '0;
            rx_shift_reg <= '0;
            rx_data_reg  <= '0;
            bit_cnt_reg  <= '0;
            gap_cnt_reg  <= '0;
            spi_cs_reg   <= 1'b1;
            mosi_reg     <= 1'b0;
            tx_ready_reg <= 1'b1;
            rx_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            spi_clk_q    <= spi_clk;
            tx_shift_reg <= tx_shift_next;
            rx_shift_reg <= rx_shift_next;
            rx_data_reg  <= rx_data_next;
            bit_cnt_reg  <= bit_cnt_next;
            gap_cnt_reg  <= gap_cnt_next;
            spi_cs_reg   <= spi_cs_next;
            mosi_reg     <= mosi_next;
            tx_ready_reg <= tx_ready_next;
            rx_valid_reg <= rx_valid_next;
            busy_reg     <= busy_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        tx_shift_next = tx_shift_reg;
        rx_shift_next = rx_shift_reg;
        rx_data_next  = rx_data_reg;
        bit_cnt_next  = bit_cnt_reg;
        gap_cnt_next  = gap_cnt_reg;
        spi_cs_next   = spi_cs_reg;
        mosi_next     = mosi_reg;
        tx_ready_next = tx_ready_reg;
        rx_valid_next = 1'b0;
        busy_next     = busy_reg;

        case (state_reg)
            IDLE: begin
                if (tx_valid && tx_ready_reg) begin
                    tx_shift_next = tx_data;
                    mosi_next     = LSB ? tx_data[0] : tx_data[DATA_W-1];
                    spi_cs_next   = 1'b0;
                    bit_cnt_next  = '0;
                    tx_ready_next = 1'b0;
                    busy_next     = 1'b1;
                    state_next    = XFER;
                end
            end
            XFER: begin
                if (rise) begin
                    rx_shift_next = LSB ? {miso, rx_shift_reg[DATA_W-1:1]}
                                        : {rx_shift_reg[DATA_W-2:0], miso};
                    bit_cnt_next  = bit_cnt_reg + CNT_W'(1);
                end else if (fall && bit_cnt_reg == CNT_W'(DATA_W)) begin
                    spi_cs_next   = 1'b1;
                    rx_data_next  = rx_shift_reg;
                    rx_valid_next = 1'b1;
                    mosi_next     = 1'b0;
                    gap_cnt_next  = '0;
                    state_next    = GAP;
                end else if (fall && bit_cnt_reg != '0) begin
                    // A fall before any rise means spi_clk was high at entry; skip it.
                    tx_shift_next = LSB ? (tx_shift_reg >> 1) : (tx_shift_reg << 1);
                    mosi_next     = LSB ? tx_shift_reg[1] : tx_shift_reg[DATA_W-2];
                end
            end
            GAP: begin
                gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                if (gap_cnt_reg == GAP_W'(CS_GAP - 1)) begin
                    gap_cnt_next  = '0;
                    tx_ready_next = 1'b1;
                    busy_next     = 1'b0;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign tx_ready = tx_ready_reg;
    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;
    assign busy     = busy_reg;
    assign spi_cs   = spi_cs_reg;
    assign mosi     = mosi_reg;

endmodule
